// File: rtl/store_write_buffer_pkg.sv
// Shared types and constants for the store write buffer and its overlap comparators.
package stb_pkg;

    typedef struct packed {
        logic [31:0] adrs;
        logic [63:0] data;
        logic        is64;
    } stb_entry_t;

    localparam int WORD_BYTES = 4;
    localparam int DBL_BYTES  = 8;
    localparam int LD_SPAN    = 8;

endpackage

// File: rtl/store_write_buffer_if.sv
// Pipeline-side and DataMemory-side signals of the store write buffer.
interface store_write_buffer_if;

    logic        St_valid;
    logic        St_is64;
    logic [31:0] St_adrs;
    logic [63:0] St_data;
    logic        St_ready;

    logic        Ld_valid;
    logic [31:0] Ld_adrs;
    logic        Ld_stall;
    logic        Ld_fwd;
    logic [31:0] Fwd_data;
    logic [31:0] Fwd_nextdata;

    logic [31:0] Adrs_MEM;
    logic [31:0] Rt_data_MEM;
    logic [63:0] Rt_data64_MEM;
    logic        MemRead;
    logic        MemWrite;
    logic        MemWrite64;
    logic        Stb_empty;

    modport master (
        output St_valid, St_is64, St_adrs, St_data, Ld_valid, Ld_adrs,
        input  St_ready, Ld_stall, Ld_fwd, Fwd_data, Fwd_nextdata,
        input  Adrs_MEM, Rt_data_MEM, Rt_data64_MEM, MemRead, MemWrite, MemWrite64, Stb_empty
    );

    modport slave (
        input  St_valid, St_is64, St_adrs, St_data, Ld_valid, Ld_adrs,
        output St_ready, Ld_stall, Ld_fwd, Fwd_data, Fwd_nextdata,
        output Adrs_MEM, Rt_data_MEM, Rt_data64_MEM, MemRead, MemWrite, MemWrite64, Stb_empty
    );

endinterface

// File: rtl/store_write_buffer_overlap_cmp.sv
// Compares one buffered store's byte range against the 8-byte load window.
module stb_overlap_cmp
    import stb_pkg::*;
(
    input  logic        valid,
    input  logic [31:0] entry_adrs,
    input  logic        entry_is64,
    input  logic [31:0] ld_adrs,
    output logic        hit,
    output logic        exact_dbl_match
);

    logic [32:0] e_start;
    logic [32:0] e_end;
    logic [32:0] l_start;
    logic [32:0] l_end;

    // 33-bit ends so ranges near the top of the address space never wrap to zero
    assign e_start = {1'b0, entry_adrs};
    assign e_end   = e_start + (entry_is64 ? 33'(DBL_BYTES - 1) : 33'(WORD_BYTES - 1));
    assign l_start = {1'b0, ld_adrs};
    assign l_end   = l_start + 33'(LD_SPAN - 1);

    assign hit             = valid && (e_start <= l_end) && (l_start <= e_end);
    assign exact_dbl_match = hit && entry_is64 && (entry_adrs == ld_adrs);

endmodule

// File: rtl/store_write_buffer.sv
// FIFO of pending stores draining into DataMemory, sharing its port with loads.
// Define STB_FWD_EN to serve exact double-word load matches straight from the buffer.
module store_write_buffer
    import stb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input logic               Clk,
    input logic               Rst_n,
    store_write_buffer_if.slave bus
);

    stb_entry_t       entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] hit_vec;
    logic [DEPTH-1:0] exact_vec;
    logic             any_hit;
    logic             fwd;
    logic             load_go;
    logic             push;
    logic             pop;
    stb_entry_t       head;

    assign head          = entries[rd_ptr];
    assign bus.St_ready  = (count != (PTR_W+1)'(DEPTH));
    assign bus.Stb_empty = (count == '0);
    assign push          = bus.St_valid && bus.St_ready;

    // An entry is live when its distance from the read pointer is below the count
    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        logic [PTR_W-1:0] offset;
        assign offset       = PTR_W'(i) - rd_ptr;
        assign valid_vec[i] = ({1'b0, offset} < count);

        stb_overlap_cmp u_cmp (
            .valid           (valid_vec[i]),
            .entry_adrs      (entries[i].adrs),
            .entry_is64      (entries[i].is64),
            .ld_adrs         (bus.Ld_adrs),
            .hit             (hit_vec[i]),
            .exact_dbl_match (exact_vec[i])
        );
    end

    assign any_hit = |hit_vec;

`ifdef STB_FWD_EN
    logic [PTR_W:0] n_hits;
    logic [63:0]    fwd_word;

    always_comb begin
        n_hits   = '0;
        fwd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n_hits = n_hits + {{PTR_W{1'b0}}, hit_vec[i]};
            if (exact_vec[i]) begin
                fwd_word = entries[i].data;
            end
        end
    end

    // Forward only when the sole overlapping entry covers the load window exactly
    assign fwd              = bus.Ld_valid && (n_hits == (PTR_W+1)'(1)) && (|exact_vec);
    assign bus.Ld_fwd       = fwd;
    assign bus.Fwd_data     = fwd ? fwd_word[63:32] : '0;
    assign bus.Fwd_nextdata = fwd ? fwd_word[31:0]  : '0;
`else
    logic unused_exact;
    assign unused_exact     = ^exact_vec;
    assign fwd              = 1'b0;
    assign bus.Ld_fwd       = 1'b0;
    assign bus.Fwd_data     = '0;
    assign bus.Fwd_nextdata = '0;
`endif

    assign load_go       = bus.Ld_valid && !any_hit;
    assign bus.Ld_stall  = bus.Ld_valid && any_hit && !fwd;
    assign bus.Rt_data_MEM   = head.data[31:0];
    assign bus.Rt_data64_MEM = head.data;

    // A blocked or forwarded load yields the port, so the drain always makes progress
    always_comb begin
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.MemWrite64 = 1'b0;
        bus.Adrs_MEM   = '0;
        pop            = 1'b0;
        if (load_go) begin
            bus.MemRead  = 1'b1;
            bus.Adrs_MEM = bus.Ld_adrs;
        end else if (count != '0) begin
            bus.Adrs_MEM   = head.adrs;
            bus.MemWrite   = !head.is64;
            bus.MemWrite64 = head.is64;
            pop            = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= '{adrs: bus.St_adrs, data: bus.St_data, is64: bus.St_is64};
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: big-endian memory model plus a drain scoreboard.
module tb_store_write_buffer;
    import stb_pkg::*;

    logic Clk;
    logic Rst_n;
    int   checks;
    int   failures;

    store_write_buffer_if bus();

    store_write_buffer dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [7:0] mem [0:1023];
    stb_entry_t sb [$];
    stb_entry_t mon_exp;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [9:0] i;
        i = a[9:0];
        return {mem[i], mem[i + 10'd1], mem[i + 10'd2], mem[i + 10'd3]};
    endfunction

    // Memory commits on negedge; each write is checked against the oldest expected store
    always @(negedge Clk) begin
        if (bus.MemWrite || bus.MemWrite64) begin
            checks++;
            if (!Rst_n) begin
                failures++;
                $display("[TB] FAIL drain_in_reset adrs=%h", bus.Adrs_MEM);
            end else if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_drain adrs=%h expected no write", bus.Adrs_MEM);
            end else begin
                mon_exp = sb.pop_front();
                if (bus.Adrs_MEM !== mon_exp.adrs || bus.MemWrite64 !== mon_exp.is64) begin
                    failures++;
                    $display("[TB] FAIL drain_adrs got %h/dbl=%b expected %h/dbl=%b",
                             bus.Adrs_MEM, bus.MemWrite64, mon_exp.adrs, mon_exp.is64);
                end
                checks++;
                if (mon_exp.is64 && bus.Rt_data64_MEM !== mon_exp.data) begin
                    failures++;
                    $display("[TB] FAIL drain_data64 got %h expected %h", bus.Rt_data64_MEM, mon_exp.data);
                end else if (!mon_exp.is64 && bus.Rt_data_MEM !== mon_exp.data[31:0]) begin
                    failures++;
                    $display("[TB] FAIL drain_data32 got %h expected %h", bus.Rt_data_MEM, mon_exp.data[31:0]);
                end
            end
            if (bus.MemWrite64) begin
                for (int b = 0; b < 8; b++)
                    mem[bus.Adrs_MEM[9:0] + 10'(b)] = bus.Rt_data64_MEM[63 - 8*b -: 8];
            end else begin
                for (int b = 0; b < 4; b++)
                    mem[bus.Adrs_MEM[9:0] + 10'(b)] = bus.Rt_data_MEM[31 - 8*b -: 8];
            end
        end
    end

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic dbl, input logic [63:0] d);
        bus.St_valid = 1'b1;
        bus.St_adrs  = a;
        bus.St_is64  = dbl;
        bus.St_data  = d;
    endtask

    // Called 1 unit after drive: checks readiness against the model and records the accept
    task automatic accept_store();
        logic exp_ready;
        exp_ready = (sb.size() != 4);
        checks++;
        if (bus.St_ready !== exp_ready) begin
            failures++;
            $display("[TB] FAIL st_ready got %b expected %b", bus.St_ready, exp_ready);
        end
        if (bus.St_valid && exp_ready)
            sb.push_back('{adrs: bus.St_adrs, data: bus.St_data, is64: bus.St_is64});
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            next_cycle();
            n++;
        end
        next_cycle();
        #1;
        checks++;
        if (sb.size() != 0 || bus.Stb_empty !== 1'b1) begin
            failures++;
            $display("[TB] FAIL drain_timeout pending=%0d Stb_empty=%b expected 0/1", sb.size(), bus.Stb_empty);
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        #2;
        checks++;
        if (bus.St_ready !== 1'b1 || bus.Stb_empty !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ready got %b/%b expected 1/1", bus.St_ready, bus.Stb_empty);
        end
        checks++;
        if ({bus.MemRead, bus.MemWrite, bus.MemWrite64, bus.Ld_stall, bus.Ld_fwd} !== 5'b0 || bus.Adrs_MEM !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_strobes got %b adrs=%h expected 00000 adrs=0",
                     {bus.MemRead, bus.MemWrite, bus.MemWrite64, bus.Ld_stall, bus.Ld_fwd}, bus.Adrs_MEM);
        end
        @(posedge Clk);
        #1 Rst_n = 1'b1;
    endtask

    task automatic test_load_empty();
        next_cycle();
        bus.Ld_valid = 1'b1;
        bus.Ld_adrs  = 32'd8;
        #1;
        checks++;
        if (bus.MemRead !== 1'b1 || bus.Adrs_MEM !== 32'd8 || bus.Ld_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL load_empty got rd=%b adrs=%h stall=%b expected 1 8 0", bus.MemRead, bus.Adrs_MEM, bus.Ld_stall);
        end
        checks++;
        if (rd_word(bus.Adrs_MEM) !== 32'h0000000C || rd_word(bus.Adrs_MEM + 32'd4) !== 32'h00000010) begin
            failures++;
            $display("[TB] FAIL load_empty_data got %h/%h expected 0000000c/00000010",
                     rd_word(bus.Adrs_MEM), rd_word(bus.Adrs_MEM + 32'd4));
        end
        next_cycle();
        bus.Ld_valid = 1'b0;
    endtask

    task automatic test_store_word();
        drive_store(32'd8, 1'b0, 64'h0000_0000_0000_1111);
        #1 accept_store();
        next_cycle();
        bus.St_valid = 1'b0;
        #1;
        checks++;
        if (bus.MemWrite !== 1'b1 || bus.MemWrite64 !== 1'b0 || bus.Adrs_MEM !== 32'd8) begin
            failures++;
            $display("[TB] FAIL store_word_drain got wr=%b wr64=%b adrs=%h expected 1 0 8", bus.MemWrite, bus.MemWrite64, bus.Adrs_MEM);
        end
        next_cycle();
        #1;
        checks++;
        if (bus.Stb_empty !== 1'b1 || {mem[8], mem[9], mem[10], mem[11]} !== 32'h00001111) begin
            failures++;
            $display("[TB] FAIL store_word_mem got empty=%b mem=%h expected 1 00001111",
                     bus.Stb_empty, {mem[8], mem[9], mem[10], mem[11]});
        end
    endtask

    task automatic test_fill_with_loads();
        logic [31:0] adrs_t [5];
        logic        dbl_t  [5];
        logic [63:0] data_t [5];
        int idx;
        adrs_t = '{32'd100, 32'd200, 32'd300, 32'd400, 32'd160};
        dbl_t  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        data_t = '{64'hA1A2A3A4, 64'h1122334455667788, 64'hB1B2B3B4, 64'hCAFEBABEDEADBEEF, 64'h55AA55AA};
        idx = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            next_cycle();
            bus.Ld_valid = (cyc < 7);
            bus.Ld_adrs  = 32'd512;
            if (idx < 5) drive_store(adrs_t[idx], dbl_t[idx], data_t[idx]);
            else         bus.St_valid = 1'b0;
            #1;
            if (bus.St_valid && sb.size() != 4) idx++;
            accept_store();
            if (cyc < 7) begin
                checks++;
                if (bus.Ld_stall !== 1'b0 || bus.MemRead !== 1'b1 || bus.MemWrite !== 1'b0 || bus.MemWrite64 !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL fill_load cyc=%0d got stall=%b rd=%b wr=%b wr64=%b expected 0 1 0 0",
                             cyc, bus.Ld_stall, bus.MemRead, bus.MemWrite, bus.MemWrite64);
                end
            end
        end
        bus.St_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_overlap_stall();
        next_cycle();
        drive_store(32'd16, 1'b1, 64'h0FFFFFFFFFFFFFFE);
        #1 accept_store();
        next_cycle();
        bus.St_valid = 1'b0;
        bus.Ld_valid = 1'b1;
        bus.Ld_adrs  = 32'd12;
        #1;
        checks++;
        if (bus.Ld_stall !== 1'b1 || bus.MemWrite64 !== 1'b1 || bus.MemRead !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overlap_stall got stall=%b wr64=%b rd=%b expected 1 1 0", bus.Ld_stall, bus.MemWrite64, bus.MemRead);
        end
        next_cycle();
        #1;
        checks++;
        if (bus.Ld_stall !== 1'b0 || bus.MemRead !== 1'b1 || bus.Adrs_MEM !== 32'd12) begin
            failures++;
            $display("[TB] FAIL overlap_retry got stall=%b rd=%b adrs=%h expected 0 1 c", bus.Ld_stall, bus.MemRead, bus.Adrs_MEM);
        end
        checks++;
        if (rd_word(32'd12) !== 32'h00000010 || rd_word(32'd16) !== 32'h0FFFFFFF) begin
            failures++;
            $display("[TB] FAIL overlap_data got %h/%h expected 00000010/0fffffff", rd_word(32'd12), rd_word(32'd16));
        end
        next_cycle();
        bus.Ld_valid = 1'b0;
    endtask

    task automatic test_overlap_bounds();
        logic [31:0] ld_t [3];
        logic        hit_t [3];
        ld_t  = '{32'd36, 32'd24, 32'd25};
        hit_t = '{1'b0, 1'b0, 1'b1};
        next_cycle();
        drive_store(32'd32, 1'b0, 64'hDEADBEEF);
        #1 accept_store();
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            bus.St_valid = 1'b0;
            bus.Ld_valid = 1'b1;
            bus.Ld_adrs  = ld_t[k];
            #1;
            checks++;
            if (bus.Ld_stall !== hit_t[k] || bus.MemRead !== !hit_t[k] || bus.MemWrite !== hit_t[k]) begin
                failures++;
                $display("[TB] FAIL bound_ld%0d got stall=%b rd=%b wr=%b expected stall=%b", ld_t[k],
                         bus.Ld_stall, bus.MemRead, bus.MemWrite, hit_t[k]);
            end
        end
        next_cycle();
        #1;
        checks++;
        if (bus.Ld_stall !== 1'b0 || bus.MemRead !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bound_after_drain got stall=%b rd=%b expected 0 1", bus.Ld_stall, bus.MemRead);
        end
        bus.Ld_valid = 1'b0;
    endtask

    task automatic test_forward();
        next_cycle();
        drive_store(32'd24, 1'b1, 64'h0123456789ABCDEF);
        #1 accept_store();
        next_cycle();
        bus.St_valid = 1'b0;
        bus.Ld_valid = 1'b1;
        bus.Ld_adrs  = 32'd24;
        #1;
        checks++;
`ifdef STB_FWD_EN
        if (bus.Ld_fwd !== 1'b1 || bus.Ld_stall !== 1'b0 || bus.Fwd_data !== 32'h01234567 ||
            bus.Fwd_nextdata !== 32'h89ABCDEF || bus.MemWrite64 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL forward got fwd=%b stall=%b %h/%h wr64=%b expected 1 0 01234567/89abcdef 1",
                     bus.Ld_fwd, bus.Ld_stall, bus.Fwd_data, bus.Fwd_nextdata, bus.MemWrite64);
        end
`else
        if (bus.Ld_fwd !== 1'b0 || bus.Ld_stall !== 1'b1 || bus.Fwd_data !== 32'h0 || bus.MemWrite64 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL no_forward got fwd=%b stall=%b fwd_data=%h wr64=%b expected 0 1 0 1",
                     bus.Ld_fwd, bus.Ld_stall, bus.Fwd_data, bus.MemWrite64);
        end
`endif
        next_cycle();
        #1;
        checks++;
        if (bus.MemRead !== 1'b1 || rd_word(bus.Adrs_MEM) !== 32'h01234567 || rd_word(bus.Adrs_MEM + 32'd4) !== 32'h89ABCDEF) begin
            failures++;
            $display("[TB] FAIL forward_mem got rd=%b %h/%h expected 1 01234567/89abcdef",
                     bus.MemRead, rd_word(bus.Adrs_MEM), rd_word(bus.Adrs_MEM + 32'd4));
        end
        bus.Ld_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            bus.Ld_valid = 1'b1;
            bus.Ld_adrs  = 32'd600;
            drive_store(32'd700 + 32'(4*k), 1'b0, 64'(32'hC0DE0000 + k));
            #1 accept_store();
        end
        next_cycle();
        bus.St_valid = 1'b0;
        #2;
        Rst_n        = 1'b0;
        bus.Ld_valid = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (bus.St_ready !== 1'b1 || bus.Stb_empty !== 1'b1 || bus.MemWrite !== 1'b0 ||
            bus.MemRead !== 1'b0 || bus.Adrs_MEM !== 32'h0 || bus.Rt_data64_MEM !== 64'h0) begin
            failures++;
            $display("[TB] FAIL reset_mid got ready=%b empty=%b wr=%b rd=%b adrs=%h data=%h expected 1 1 0 0 0 0",
                     bus.St_ready, bus.Stb_empty, bus.MemWrite, bus.MemRead, bus.Adrs_MEM, bus.Rt_data64_MEM);
        end
        next_cycle();
        next_cycle();
        Rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            #1;
            checks++;
            if (bus.MemWrite !== 1'b0 || bus.MemWrite64 !== 1'b0 || bus.Stb_empty !== 1'b1) begin
                failures++;
                $display("[TB] FAIL reset_mid_idle got wr=%b wr64=%b empty=%b expected 0 0 1", bus.MemWrite, bus.MemWrite64, bus.Stb_empty);
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rd_word(32'd700 + 32'(4*k)) !== 32'd704 + 32'(4*k)) begin
                failures++;
                $display("[TB] FAIL reset_mid_mem%0d got %h expected %h", k, rd_word(32'd700 + 32'(4*k)), 32'd704 + 32'(4*k));
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        for (int a = 0; a < 1024; a += 4) begin
            mem[a]     = 8'((a + 4) >> 24);
            mem[a + 1] = 8'((a + 4) >> 16);
            mem[a + 2] = 8'((a + 4) >> 8);
            mem[a + 3] = 8'(a + 4);
        end
        bus.St_valid = 1'b0;
        bus.St_is64  = 1'b0;
        bus.St_adrs  = '0;
        bus.St_data  = '0;
        bus.Ld_valid = 1'b0;
        bus.Ld_adrs  = '0;

        test_reset();
        test_load_empty();
        test_store_word();
        test_fill_with_loads();
        test_overlap_stall();
        test_overlap_bounds();
        test_forward();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
